vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters:
  - the display fetch path, paced by the timing generator's de/vs outputs;
  - a host read/write port.
- Display fetch has absolute priority during active video. Host accesses are granted only in blanking.
- Generates the linear frame read address internally and returns pixel data with a fixed latency. Downstream delays de/hs/vs by the same amount.

---
 rtl/vram_arbiter_pkg.sv | 18 +
 rtl/vram_arbiter_if.sv | 43 ++++
 rtl/vram_rd_pipe.sv | 58 +++++
 rtl/vram_arbiter.sv | 110 +++++++++++
 tb/tb_vram_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared video definitions: RAM geometry, supported frame sizes, fetch latency.
// FETCH_LAT is the delay the sync-delay line applies to de/hs/vs downstream.
package vram_arbiter_pkg;

  localparam int VRAM_AW           = 15;
  localparam int VRAM_DW           = 8;
  localparam int FRAME_PIX_160X120 = 19200;
  localparam int FRAME_PIX_128X96  = 12288;
  localparam int FETCH_LAT         = 3;
  localparam int WAIT_W            = 10;

  // Identifies what a RAM read in flight belongs to; host writes carry no tag.
  typedef struct packed {
    logic host_rd;
    logic disp;
  } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Display-timing, host-port and RAM-port bundle of the video RAM arbiter.
// slave = arbiter side, master = environment (timing gen, host, RAM).
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
);

  logic          i_de;
  logic          i_vs;
  logic [DW-1:0] o_disp_data;
  logic          o_disp_valid;
  logic          i_host_valid;
  logic          o_host_ready;
  logic          i_host_we;
  logic [AW-1:0] i_host_addr;
  logic [DW-1:0] i_host_wdata;
  logic [DW-1:0] o_host_rdata;
  logic          o_host_rvalid;
  logic          o_host_starved;
  logic          i_clr_starved;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_de, i_vs, i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    input  i_clr_starved, i_mem_rdata,
    output o_disp_data, o_disp_valid, o_host_ready, o_host_rdata, o_host_rvalid,
    output o_host_starved, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_de, i_vs, i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    output i_clr_starved, i_mem_rdata,
    input  o_disp_data, o_disp_valid, o_host_ready, o_host_rdata, o_host_rvalid,
    input  o_host_starved, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/vram_rd_pipe.sv
// Read-return pipeline: tag follows each read for 2 stages, data lands at grant+3.
// No backpressure; valids are single-cycle, data registers hold their last value.
module vram_rd_pipe
  import vram_arbiter_pkg::*;
#(
  parameter int DW = VRAM_DW
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  tag_t          i_tag,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [DW-1:0] o_disp_data,
  output logic          o_disp_valid,
  output logic [DW-1:0] o_host_rdata,
  output logic          o_host_rvalid
);

  tag_t          tag1_d, tag1_q;
  tag_t          tag2_d, tag2_q;
  logic [DW-1:0] disp_data_d, disp_data_q;
  logic          disp_valid_d, disp_valid_q;
  logic [DW-1:0] host_rdata_d, host_rdata_q;
  logic          host_rvalid_d, host_rvalid_q;

  // tag1 aligns with the registered RAM command, tag2 with the RAM read data.
  always_comb begin
    tag1_d        = i_tag;
    tag2_d        = tag1_q;
    disp_valid_d  = tag2_q.disp;
    host_rvalid_d = tag2_q.host_rd;
    disp_data_d   = tag2_q.disp    ? i_mem_rdata : disp_data_q;
    host_rdata_d  = tag2_q.host_rd ? i_mem_rdata : host_rdata_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tag1_q        <= '0;
      tag2_q        <= '0;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign o_disp_data   = disp_data_q;
  assign o_disp_valid  = disp_valid_q;
  assign o_host_rdata  = host_rdata_q;
  assign o_host_rvalid = host_rvalid_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns the RAM while de=1, host only in blanking.
// Display data returns 3 cycles after de; host is held off (ready=!de) with starvation flag.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int AW        = VRAM_AW,
  parameter int DW        = VRAM_DW,
  parameter int FRAME_PIX = FRAME_PIX_160X120,
  parameter int MAX_WAIT  = 1023
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  vram_arbiter_if.slave  bus
);

  localparam logic [AW-1:0]     LAST_PIX = AW'(FRAME_PIX - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic              host_ready;
  logic              host_go;
  logic              host_wait;
  tag_t              grant_tag;
  logic [AW-1:0]     frame_addr_d, frame_addr_q;
  logic              mem_en_d, mem_en_q;
  logic              mem_we_d, mem_we_q;
  logic [AW-1:0]     mem_addr_d, mem_addr_q;
  logic [DW-1:0]     mem_wdata_d, mem_wdata_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic              starved_d, starved_q;

  assign host_ready = !bus.i_de;
  assign host_go    = bus.i_host_valid && host_ready;
  assign host_wait  = bus.i_host_valid && !host_ready;

  always_comb begin
    frame_addr_d = frame_addr_q;
    if (bus.i_vs) begin
      frame_addr_d = '0;
    end else if (bus.i_de) begin
      frame_addr_d = (frame_addr_q == LAST_PIX) ? '0 : frame_addr_q + 1'b1;
    end
  end

  // Address/wdata hold when idle so the RAM bus does not toggle needlessly.
  always_comb begin
    mem_en_d    = bus.i_de || host_go;
    mem_we_d    = host_go && bus.i_host_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_tag   = '0;
    if (bus.i_de) begin
      mem_addr_d     = frame_addr_q;
      grant_tag.disp = 1'b1;
    end else if (host_go) begin
      mem_addr_d        = bus.i_host_addr;
      mem_wdata_d       = bus.i_host_wdata;
      grant_tag.host_rd = !bus.i_host_we;
    end
  end

  // A still-starving host re-asserts the flag even while it is being cleared.
  always_comb begin
    wait_d = '0;
    if (host_wait) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end
    starved_d = (wait_d >= WAIT_LIM) || (starved_q && !bus.i_clr_starved);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      frame_addr_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wait_q       <= '0;
      starved_q    <= 1'b0;
    end else begin
      frame_addr_q <= frame_addr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wait_q       <= wait_d;
      starved_q    <= starved_d;
    end
  end

  assign bus.o_host_ready   = host_ready;
  assign bus.o_host_starved = starved_q;
  assign bus.o_mem_en       = mem_en_q;
  assign bus.o_mem_we       = mem_we_q;
  assign bus.o_mem_addr     = mem_addr_q;
  assign bus.o_mem_wdata    = mem_wdata_q;

  vram_rd_pipe #(
    .DW (DW)
  ) u_rd_pipe (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_tag         (grant_tag),
    .i_mem_rdata   (bus.i_mem_rdata),
    .o_disp_data   (bus.o_disp_data),
    .o_disp_valid  (bus.o_disp_valid),
    .o_host_rdata  (bus.o_host_rdata),
    .o_host_rvalid (bus.o_host_rvalid)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small frame (4 pixels) and short starvation limit (8).
// RAM model: unwritten word at address a reads as 8'hA0 | a.
module tb_vram_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .FRAME_PIX (4),
    .MAX_WAIT  (8)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:31];
  bit         wr  [0:31];

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) begin
        ram[bus.o_mem_addr[4:0]] <= bus.o_mem_wdata;
        wr[bus.o_mem_addr[4:0]]  <= 1'b1;
      end else begin
        bus.i_mem_rdata <= wr[bus.o_mem_addr[4:0]] ? ram[bus.o_mem_addr[4:0]]
                                                   : (8'hA0 | {3'b000, bus.o_mem_addr[4:0]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.i_de          = 1'b0;
    bus.i_vs          = 1'b0;
    bus.i_host_valid  = 1'b0;
    bus.i_host_we     = 1'b0;
    bus.i_host_addr   = '0;
    bus.i_host_wdata  = '0;
    bus.i_clr_starved = 1'b0;
    bus.i_mem_rdata   = '0;
    repeat (3) cyc();

    // reset state
    chk("rst_mem_en",      bus.o_mem_en, 0);
    chk("rst_mem_we",      bus.o_mem_we, 0);
    chk("rst_mem_addr",    bus.o_mem_addr, 0);
    chk("rst_mem_wdata",   bus.o_mem_wdata, 0);
    chk("rst_disp_valid",  bus.o_disp_valid, 0);
    chk("rst_disp_data",   bus.o_disp_data, 0);
    chk("rst_host_rvalid", bus.o_host_rvalid, 0);
    chk("rst_host_rdata",  bus.o_host_rdata, 0);
    chk("rst_starved",     bus.o_host_starved, 0);
    chk("rst_host_ready",  bus.o_host_ready, 1);

    // reset mid-stream: fetches in flight are discarded
    rstn = 1'b1;
    bus.i_vs = 1'b1;
    cyc();
    bus.i_vs = 1'b0;
    bus.i_de = 1'b1;
    repeat (3) cyc();
    rstn = 1'b0;
    #1;
    chk("rst_async_mem_en",     bus.o_mem_en, 0);
    chk("rst_async_disp_valid", bus.o_disp_valid, 0);
    cyc();
    cyc();
    rstn = 1'b1;
    bus.i_de = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_rel_disp_valid", bus.o_disp_valid, 0);
      chk("rst_rel_mem_en",     bus.o_mem_en, 0);
    end
    chk("rst_rel_mem_addr", bus.o_mem_addr, 0);
    chk("rst_rel_mem_we",   bus.o_mem_we, 0);
    bus.i_de = 1'b1;
    cyc();
    bus.i_de = 1'b0;
    chk("post_rst_addr",   bus.o_mem_addr, 0);
    chk("post_rst_mem_en", bus.o_mem_en, 1);
    cyc();
    cyc();
    chk("post_rst_valid", bus.o_disp_valid, 1);
    chk("post_rst_data",  bus.o_disp_data, 8'hA0);

    // display fetch after vs: addresses 0..3, data A0..A3 at t+3..t+6
    bus.i_vs = 1'b1;
    cyc();
    bus.i_vs = 1'b0;
    bus.i_de = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      if (i == 4) bus.i_de = 1'b0;
      if (i <= 4) begin
        chk("fetch_addr",   bus.o_mem_addr, i - 1);
        chk("fetch_mem_en", bus.o_mem_en, 1);
        chk("fetch_mem_we", bus.o_mem_we, 0);
      end else begin
        chk("fetch_idle_en", bus.o_mem_en, 0);
      end
      if (i >= 3 && i <= 6) begin
        chk("fetch_valid", bus.o_disp_valid, 1);
        chk("fetch_data",  bus.o_disp_data, 8'hA0 + (i - 3));
      end else begin
        chk("fetch_novalid", bus.o_disp_valid, 0);
      end
    end

    // wrap without vs: 0,1,2,3,0,1
    bus.i_de = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 6) bus.i_de = 1'b0;
      chk("wrap_addr", bus.o_mem_addr, (i - 1) % 4);
    end
    repeat (4) cyc();

    // host write then read of address 5 in blanking
    bus.i_host_valid = 1'b1;
    bus.i_host_we    = 1'b1;
    bus.i_host_addr  = 15'd5;
    bus.i_host_wdata = 8'h5A;
    #1;
    chk("hw_ready", bus.o_host_ready, 1);
    cyc();
    chk("hw_mem_en",    bus.o_mem_en, 1);
    chk("hw_mem_we",    bus.o_mem_we, 1);
    chk("hw_mem_addr",  bus.o_mem_addr, 5);
    chk("hw_mem_wdata", bus.o_mem_wdata, 8'h5A);
    bus.i_host_we = 1'b0;
    #1;
    chk("hr_ready", bus.o_host_ready, 1);
    cyc();
    bus.i_host_valid = 1'b0;
    chk("hr_mem_en",   bus.o_mem_en, 1);
    chk("hr_mem_we",   bus.o_mem_we, 0);
    chk("hr_mem_addr", bus.o_mem_addr, 5);
    chk("hr_rvalid_early", bus.o_host_rvalid, 0);
    cyc();
    chk("hw_no_rvalid", bus.o_host_rvalid, 0);
    chk("h_idle_en",    bus.o_mem_en, 0);
    cyc();
    chk("hr_rvalid",     bus.o_host_rvalid, 1);
    chk("hr_rdata",      bus.o_host_rdata, 8'h5A);
    chk("hr_disp_quiet", bus.o_disp_valid, 0);
    cyc();
    chk("hr_rvalid_drop", bus.o_host_rvalid, 0);
    chk("hr_rdata_hold",  bus.o_host_rdata, 8'h5A);

    // contention: host held off for 3 de cycles, accepted on first blank cycle
    bus.i_de         = 1'b1;
    bus.i_host_valid = 1'b1;
    bus.i_host_we    = 1'b0;
    bus.i_host_addr  = 15'd7;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("cont_ready_low", bus.o_host_ready, 0);
      cyc();
      chk("cont_mem_en",   bus.o_mem_en, 1);
      chk("cont_mem_we",   bus.o_mem_we, 0);
      chk("cont_disp_addr", bus.o_mem_addr, (2 + j) % 4);
    end
    bus.i_de = 1'b0;
    chk("cont_disp_valid0", bus.o_disp_valid, 1);
    chk("cont_disp_data0",  bus.o_disp_data, 8'hA2);
    #1;
    chk("cont_ready_high", bus.o_host_ready, 1);
    cyc();
    bus.i_host_valid = 1'b0;
    chk("cont_host_addr",   bus.o_mem_addr, 7);
    chk("cont_host_en",     bus.o_mem_en, 1);
    chk("cont_disp_data1",  bus.o_disp_data, 8'hA3);
    cyc();
    chk("cont_disp_data2",  bus.o_disp_data, 8'hA0);
    chk("cont_rvalid_early", bus.o_host_rvalid, 0);
    cyc();
    chk("cont_rvalid",      bus.o_host_rvalid, 1);
    chk("cont_rdata",       bus.o_host_rdata, 8'hA7);
    chk("cont_disp_done",   bus.o_disp_valid, 0);
    chk("cont_not_starved", bus.o_host_starved, 0);

    // starvation: flag rises after 8 wait cycles; set beats clear
    bus.i_de         = 1'b1;
    bus.i_host_valid = 1'b1;
    bus.i_host_addr  = 15'd9;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      chk("starve_rise", bus.o_host_starved, (n >= 8) ? 1 : 0);
    end
    bus.i_clr_starved = 1'b1;
    cyc();
    chk("starve_set_wins", bus.o_host_starved, 1);
    bus.i_host_valid = 1'b0;
    cyc();
    chk("starve_clear", bus.o_host_starved, 0);
    bus.i_clr_starved = 1'b0;
    bus.i_de          = 1'b0;
    cyc();
    chk("starve_stays_clear", bus.o_host_starved, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
